cpu_rf_read: RTL and testbench
==============================

Name: cpu_rf_read

Overview:
- Operand-read stage of the pipeline: the read-side counterpart of the writeback stage.
- Accepts a decoded instruction and fetches source operands from the committed register state.
- Bypasses same-cycle writeback data and tracks in-flight destinations with a scoreboard, stalling on hazards.
- Delivers operands to execute through a registered valid/ready interface.

Parameters:
NREGS, 4, number of architectural registers
DW, 8, register data width
IW, 2, register index width (clog2(NREGS))
OPW, 8, opcode field width passed through untouched
CW, 16, width of stall-cycle counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
regs  in  NREGS*DW  committed register state; reg i at bits [i*DW +: DW]
wb_valid  in  1  writeback commits this cycle
wb_idx  in  IW  writeback destination index
wb_val  in  DW  writeback data
id_valid  in  1  decoded instruction offered
id_ready  out  1  stage accepts instruction this cycle
id_op  in  OPW  opcode
id_src_a  in  IW  source A index
id_src_b  in  IW  source B index
id_use_b  in  1  source B is read; ignore id_src_b for hazards when 0
id_dst  in  IW  destination index
id_wen  in  1  instruction writes id_dst
ex_valid  out  1  operands valid to execute
ex_ready  in  1  execute accepts
ex_op  out  OPW  registered opcode
ex_a  out  DW  operand A
ex_b  out  DW  operand B (0 when id_use_b=0)
ex_dst  out  IW  registered destination
ex_wen  out  1  registered write enable
busy  out  NREGS  scoreboard, bit i = reg i has a pending write
stall_cnt  out  CW  saturating count of hazard-stall cycles

Behaviour:
- Reset (rst_n low, async): ex_valid=0; ex_op, ex_a, ex_b, ex_dst, ex_wen=0; busy=0; stall_cnt=0; id_ready=0 while rst_n low. Reset mid-transfer drops the held instruction with no replay.
- Operand select, per source s:
  - wb_valid && wb_idx==s: value is wb_val (bypass).
  - Otherwise: value is regs[s].
- Hazard, per used source s (A always; B only if id_use_b):
  - busy[s] && !(wb_valid && wb_idx==s).
- WAW hazard:
  - id_wen && busy[id_dst] && !(wb_valid && wb_idx==id_dst).
- hazard = any source hazard OR WAW hazard.
- id_ready = rst_n && !hazard && (!ex_valid || ex_ready). This is combinational and must not depend on id_valid.
- Accept = id_valid && id_ready. On accept, next cycle:
  - ex_valid=1.
  - ex_* hold the selected operands and the passthrough fields.
  - Latency: exactly 1 cycle.
- No accept but ex_valid && ex_ready: ex_valid=0, and ex_* data holds its last value.
- ex_valid && !ex_ready: all ex_* are held stable, and id_ready=0.
- Scoreboard update each cycle:
  - Clear busy[wb_idx] if wb_valid.
  - Then set busy[id_dst] if accept && id_wen.
  - When both hit the same index, set wins and the result is 1.
- wb_valid for an index whose busy bit is 0 is legal: the bypass still applies and busy stays 0.
- stall_cnt increments when id_valid && hazard. It saturates at 2^CW-1 and never wraps.
- Backpressure-only stalls (ex_valid && !ex_ready with no hazard) are not counted.
- No combinational path from ex_ready to ex_valid. The path from ex_ready to id_ready is allowed.

Decomposition:
- Shared package cpu_pkg holds:
  - NREGS, DW, IW, OPW.
  - The reg_idx_t and reg_val_t typedefs.
  - The packed register-array typedef also used by writeback.
- One sub-module, cpu_scoreboard, owns:
  - busy[] with set/clear priority.
  - The per-index hazard lookup function with bypass qualification.
- Operand muxing and the ex pipeline register stay in cpu_rf_read.

Test Plan:
- Basic read: regs={r0=5,r1=7,r2=9,r3=11}; issue src_a=1, src_b=2, use_b=1, wen=0; ex_ready=1. Expected: ex_valid=1 one cycle later, ex_a=7, ex_b=9, busy=0, stall_cnt=0.
- Bypass: same cycle as issue src_a=3, drive wb_valid=1, wb_idx=3, wb_val=200 with regs r3=11. Expected: ex_a=200.
- RAW stall:
  - Issue dst=2, wen=1, which sets busy=0100.
  - Next instruction has src_a=2: id_ready=0 for 3 cycles, stall_cnt=3.
  - wb_valid, idx=2, val=42 arrives. Expected: accepted that cycle, ex_a=42, busy=0000.
- Set/clear collision: busy[1]=1; wb_valid idx=1 in the same cycle as accept of dst=1, wen=1. Expected: busy[1]=1 afterwards.
- Backpressure: ex_ready=0 for 4 cycles with ex_valid=1. Expected: ex_a/ex_b/ex_op stable, id_ready=0, stall_cnt unchanged. Release ex_ready and the next instruction is accepted.
- Reset mid-operation: assert rst_n low asynchronously while ex_valid=1, busy=1010, stall_cnt=5. Expected: all immediately 0, id_ready=0. After release, the first issue behaves as in the basic read test.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: register index/value widths and the packed register file
// seen by both the operand-read and writeback stages.
package cpu_pkg;
  localparam int NREGS = 4;
  localparam int DW    = 8;
  localparam int IW    = 2;
  localparam int OPW   = 8;

  typedef logic [IW-1:0]             reg_idx_t;
  typedef logic [DW-1:0]             reg_val_t;
  typedef logic [OPW-1:0]            opcode_t;
  typedef logic [NREGS-1:0][DW-1:0]  reg_file_t;
endpackage

// File: rtl/cpu_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, plus RAW/WAW hazard
// detection that treats a same-cycle writeback as already resolved.
module cpu_scoreboard
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  input  reg_idx_t         wb_idx,
  input  logic             set_en,
  input  reg_idx_t         set_idx,
  input  reg_idx_t         src_a,
  input  reg_idx_t         src_b,
  input  logic             use_b,
  input  reg_idx_t         dst,
  input  logic             wen,
  output logic [NREGS-1:0] busy,
  output logic             hazard
);

  logic [NREGS-1:0] busy_nxt;

  function automatic logic pending(input logic [NREGS-1:0] bv, input reg_idx_t idx,
                                   input logic wv, input reg_idx_t wi);
    return bv[idx] && !(wv && (wi == idx));
  endfunction

  assign hazard = pending(busy, src_a, wb_valid, wb_idx)
                | (use_b && pending(busy, src_b, wb_valid, wb_idx))
                | (wen && pending(busy, dst, wb_valid, wb_idx));

  // Clear first, then set, so an issue that reuses the retiring index stays busy.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) busy_nxt[wb_idx] = 1'b0;
    if (set_en)   busy_nxt[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: rtl/cpu_rf_read.sv
// Operand-read stage: selects operands (with writeback bypass), stalls on
// scoreboard hazards and registers the result toward execute.
module cpu_rf_read
  import cpu_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  reg_file_t        regs,
  input  logic             wb_valid,
  input  reg_idx_t         wb_idx,
  input  reg_val_t         wb_val,
  input  logic             id_valid,
  output logic             id_ready,
  input  opcode_t          id_op,
  input  reg_idx_t         id_src_a,
  input  reg_idx_t         id_src_b,
  input  logic             id_use_b,
  input  reg_idx_t         id_dst,
  input  logic             id_wen,
  output logic             ex_valid,
  input  logic             ex_ready,
  output opcode_t          ex_op,
  output reg_val_t         ex_a,
  output reg_val_t         ex_b,
  output reg_idx_t         ex_dst,
  output logic             ex_wen,
  output logic [NREGS-1:0] busy,
  output logic [CW-1:0]    stall_cnt
);

  logic          hazard;
  logic          accept;
  reg_val_t      opa_p0, opb_p0;
  logic          vld_p1;
  opcode_t       op_p1;
  reg_val_t      a_p1, b_p1;
  reg_idx_t      dst_p1;
  logic          wen_p1;
  logic [CW-1:0] stall_p1;

  function automatic reg_val_t sel_operand(input reg_file_t rf, input reg_idx_t idx,
                                           input logic wv, input reg_idx_t wi,
                                           input reg_val_t wval);
    return (wv && (wi == idx)) ? wval : rf[idx];
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  cpu_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (wb_valid),
    .wb_idx   (wb_idx),
    .set_en   (accept && id_wen),
    .set_idx  (id_dst),
    .src_a    (id_src_a),
    .src_b    (id_src_b),
    .use_b    (id_use_b),
    .dst      (id_dst),
    .wen      (id_wen),
    .busy     (busy),
    .hazard   (hazard)
  );

  assign id_ready = rst_n && !hazard && (!vld_p1 || ex_ready);
  assign accept   = id_valid && id_ready;

  assign opa_p0 = sel_operand(regs, id_src_a, wb_valid, wb_idx, wb_val);
  assign opb_p0 = id_use_b ? sel_operand(regs, id_src_b, wb_valid, wb_idx, wb_val) : '0;

  // p0 -> p1: execute-facing register, held while execute backpressures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      op_p1    <= '0;
      a_p1     <= '0;
      b_p1     <= '0;
      dst_p1   <= '0;
      wen_p1   <= 1'b0;
      stall_p1 <= '0;
    end else begin
      if (accept) begin
        vld_p1 <= 1'b1;
        op_p1  <= id_op;
        a_p1   <= opa_p0;
        b_p1   <= opb_p0;
        dst_p1 <= id_dst;
        wen_p1 <= id_wen;
      end else if (vld_p1 && ex_ready) begin
        vld_p1 <= 1'b0;
      end
      if (id_valid && hazard) stall_p1 <= sat_inc(stall_p1);
    end
  end

  assign ex_valid  = vld_p1;
  assign ex_op     = op_p1;
  assign ex_a      = a_p1;
  assign ex_b      = b_p1;
  assign ex_dst    = dst_p1;
  assign ex_wen    = wen_p1;
  assign stall_cnt = stall_p1;

endmodule

// File: tb/tb_cpu_rf_read.sv
// Directed bench for cpu_rf_read: reads, bypass, RAW/WAW stalls, backpressure,
// async reset and stall counter saturation.
module tb_cpu_rf_read;
  import cpu_pkg::*;

  localparam int CW_T = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  reg_file_t        regs;
  logic             wb_valid;
  reg_idx_t         wb_idx;
  reg_val_t         wb_val;
  logic             id_valid;
  logic             id_ready;
  opcode_t          id_op;
  reg_idx_t         id_src_a;
  reg_idx_t         id_src_b;
  logic             id_use_b;
  reg_idx_t         id_dst;
  logic             id_wen;
  logic             ex_valid;
  logic             ex_ready;
  opcode_t          ex_op;
  reg_val_t         ex_a;
  reg_val_t         ex_b;
  reg_idx_t         ex_dst;
  logic             ex_wen;
  logic [NREGS-1:0] busy;
  logic [CW_T-1:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  cpu_rf_read #(.CW(CW_T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .regs      (regs),
    .wb_valid  (wb_valid),
    .wb_idx    (wb_idx),
    .wb_val    (wb_val),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_op     (id_op),
    .id_src_a  (id_src_a),
    .id_src_b  (id_src_b),
    .id_use_b  (id_use_b),
    .id_dst    (id_dst),
    .id_wen    (id_wen),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_op     (ex_op),
    .ex_a      (ex_a),
    .ex_b      (ex_b),
    .ex_dst    (ex_dst),
    .ex_wen    (ex_wen),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input opcode_t op, input reg_idx_t a, input reg_idx_t b,
                       input logic ub, input reg_idx_t d, input logic w);
    id_valid = 1'b1;
    id_op    = op;
    id_src_a = a;
    id_src_b = b;
    id_use_b = ub;
    id_dst   = d;
    id_wen   = w;
  endtask

  task automatic wb(input logic v, input reg_idx_t i, input reg_val_t val);
    wb_valid = v;
    wb_idx   = i;
    wb_val   = val;
  endtask

  initial begin
    rst_n    = 1'b0;
    regs[0]  = 8'd5;
    regs[1]  = 8'd7;
    regs[2]  = 8'd9;
    regs[3]  = 8'd11;
    wb(1'b0, 2'd0, 8'd0);
    id_valid = 1'b0;
    id_op = '0; id_src_a = '0; id_src_b = '0; id_use_b = 1'b0; id_dst = '0; id_wen = 1'b0;
    ex_ready = 1'b1;

    #2;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_id_ready", id_ready, 0);
    tick(); tick();
    rst_n = 1'b1;

    // basic read
    issue(8'h11, 2'd1, 2'd2, 1'b1, 2'd0, 1'b0);
    #1 chk("basic_id_ready", id_ready, 1);
    tick();
    id_valid = 1'b0;
    chk("basic_ex_valid", ex_valid, 1);
    chk("basic_ex_a", ex_a, 7);
    chk("basic_ex_b", ex_b, 9);
    chk("basic_ex_op", ex_op, 8'h11);
    chk("basic_busy", busy, 0);
    chk("basic_stall", stall_cnt, 0);

    // bypass on source A, B unused reads as 0
    issue(8'h22, 2'd3, 2'd2, 1'b0, 2'd0, 1'b0);
    wb(1'b1, 2'd3, 8'd200);
    #1 chk("byp_id_ready", id_ready, 1);
    tick();
    id_valid = 1'b0; wb_valid = 1'b0;
    chk("byp_ex_valid", ex_valid, 1);
    chk("byp_ex_a", ex_a, 200);
    chk("byp_ex_b", ex_b, 0);

    // RAW stall on r2
    issue(8'h33, 2'd0, 2'd0, 1'b0, 2'd2, 1'b1);
    tick();
    chk("raw_busy_set", busy, 4'b0100);
    chk("raw_ex_dst", ex_dst, 2);
    chk("raw_ex_wen", ex_wen, 1);
    issue(8'h34, 2'd2, 2'd0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("raw_id_ready_stall", id_ready, 0);
      tick();
    end
    chk("raw_stall_cnt", stall_cnt, 3);
    chk("raw_ex_valid_drained", ex_valid, 0);
    wb(1'b1, 2'd2, 8'd42);
    #1 chk("raw_id_ready_wb", id_ready, 1);
    tick();
    id_valid = 1'b0; wb_valid = 1'b0;
    chk("raw_ex_a", ex_a, 42);
    chk("raw_busy_clr", busy, 0);
    chk("raw_stall_hold", stall_cnt, 3);

    // set/clear collision on r1
    issue(8'h44, 2'd0, 2'd0, 1'b0, 2'd1, 1'b1);
    tick();
    chk("col_busy_pre", busy, 4'b0010);
    issue(8'h45, 2'd0, 2'd0, 1'b0, 2'd1, 1'b1);
    wb(1'b1, 2'd1, 8'd9);
    #1 chk("col_id_ready", id_ready, 1);
    tick();
    id_valid = 1'b0;
    chk("col_busy_post", busy, 4'b0010);
    tick();
    wb_valid = 1'b0;
    chk("col_busy_clr", busy, 0);
    chk("col_ex_valid", ex_valid, 0);

    // backpressure
    ex_ready = 1'b0;
    issue(8'h55, 2'd1, 2'd3, 1'b1, 2'd0, 1'b0);
    tick();
    chk("bp_ex_valid", ex_valid, 1);
    issue(8'h66, 2'd2, 2'd0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp_id_ready", id_ready, 0);
      tick();
      chk("bp_ex_valid_hold", ex_valid, 1);
      chk("bp_ex_op_hold", ex_op, 8'h55);
      chk("bp_ex_a_hold", ex_a, 7);
      chk("bp_ex_b_hold", ex_b, 11);
    end
    chk("bp_stall", stall_cnt, 3);
    ex_ready = 1'b1;
    #1 chk("bp_release_ready", id_ready, 1);
    tick();
    id_valid = 1'b0;
    chk("bp_next_op", ex_op, 8'h66);
    chk("bp_next_a", ex_a, 9);

    // build busy=1010, stall=5, ex_valid=1 then async reset
    issue(8'h71, 2'd0, 2'd0, 1'b0, 2'd1, 1'b1);
    tick();
    issue(8'h72, 2'd0, 2'd0, 1'b0, 2'd3, 1'b1);
    tick();
    ex_ready = 1'b0;
    issue(8'h73, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0);
    tick(); tick();
    chk("pre_rst_busy", busy, 4'b1010);
    chk("pre_rst_stall", stall_cnt, 5);
    chk("pre_rst_ex_valid", ex_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ex_valid", ex_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_id_ready", id_ready, 0);
    chk("arst_ex_fields", {ex_op, ex_a, ex_b, ex_dst, ex_wen}, 0);
    id_valid = 1'b0;
    ex_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    issue(8'h11, 2'd1, 2'd2, 1'b1, 2'd0, 1'b0);
    tick();
    id_valid = 1'b0;
    chk("post_rst_ex_valid", ex_valid, 1);
    chk("post_rst_ex_a", ex_a, 7);
    chk("post_rst_ex_b", ex_b, 9);
    chk("post_rst_busy", busy, 0);

    // stall counter saturates at 2^CW-1
    issue(8'h81, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1);
    tick();
    issue(8'h82, 2'd3, 2'd0, 1'b1, 2'd2, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", stall_cnt, (1 << CW_T) - 1);
    chk("sat_hazard_b", id_ready, 0);
    id_valid = 1'b0;
    tick();
    chk("sat_hold", stall_cnt, (1 << CW_T) - 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
